// File: rtl/inst_mem_loader.sv
// Byte-stream loader for the instruction memory write port.
// Assembles little-endian 32-bit words, writes one word per instruction and
// verifies a trailing 8-bit checksum that makes the byte sum wrap to zero.
module inst_mem_loader #(
  parameter int unsigned MEM_BYTES = 120,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned CNT_W     = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  words_loaded
);

  localparam int unsigned EXT_W = ADDR_W + CNT_W + 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] base_q, base_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [2:0][7:0]   byte_buf, buf_n;
  logic [1:0]        byte_idx, idx_n;
  logic [7:0]        sum_q, sum_n;
  logic              in_ready_n, wr_en_n, busy_n, done_n, error_n;
  logic [ADDR_W-1:0] wr_addr_n;
  logic [31:0]       wr_data_n;
  logic [CNT_W-1:0]  words_n;
  logic [EXT_W-1:0]  end_addr;
  logic              bad_req;
  logic              take;

  // Request validation at full width so the end-address check cannot wrap
  assign take     = in_valid & in_ready;
  assign end_addr = EXT_W'(base_addr) + (EXT_W'(word_count) << 2);
  assign bad_req  = (base_addr[1:0] != 2'b00) || (word_count == '0) ||
                    (end_addr > EXT_W'(MEM_BYTES));

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      base_q       <= '0;
      cnt_q        <= '0;
      byte_buf     <= '0;
      byte_idx     <= '0;
      sum_q        <= '0;
      in_ready     <= 1'b0;
      wr_en        <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      words_loaded <= '0;
    end else begin
      state        <= state_n;
      base_q       <= base_n;
      cnt_q        <= cnt_n;
      byte_buf     <= buf_n;
      byte_idx     <= idx_n;
      sum_q        <= sum_n;
      in_ready     <= in_ready_n;
      wr_en        <= wr_en_n;
      busy         <= busy_n;
      done         <= done_n;
      error        <= error_n;
      wr_addr      <= wr_addr_n;
      wr_data      <= wr_data_n;
      words_loaded <= words_n;
    end
  end

  // Next-state and next-output decode; flags follow the next state so they
  // line up with the state register
  always_comb begin
    state_n   = state;
    base_n    = base_q;
    cnt_n     = cnt_q;
    buf_n     = byte_buf;
    idx_n     = byte_idx;
    sum_n     = sum_q;
    error_n   = error;
    wr_addr_n = wr_addr;
    wr_data_n = wr_data;
    words_n   = words_loaded;

    case (state)
      IDLE: begin
        if (start) begin
          base_n  = base_addr;
          cnt_n   = word_count;
          error_n = bad_req;
          words_n = '0;
          sum_n   = '0;
          idx_n   = '0;
          state_n = bad_req ? DONE : RECV;
        end
      end
      RECV: begin
        if (take) begin
          sum_n = 8'(sum_q + in_data);
          case (byte_idx)
            2'd0: buf_n[0] = in_data;
            2'd1: buf_n[1] = in_data;
            2'd2: buf_n[2] = in_data;
            default: begin
              wr_addr_n = ADDR_W'(base_q + (ADDR_W'(words_loaded) << 2));
              wr_data_n = {in_data, byte_buf[2], byte_buf[1], byte_buf[0]};
              state_n   = WRITE;
            end
          endcase
          idx_n = 2'(byte_idx + 2'd1);
        end
      end
      WRITE: begin
        words_n = CNT_W'(words_loaded + CNT_W'(1));
        state_n = (words_n == cnt_q) ? CHECK : RECV;
      end
      CHECK: begin
        if (take) begin
          error_n = (8'(sum_q + in_data) != 8'h00);
          state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    in_ready_n = (state_n == RECV) || (state_n == CHECK);
    wr_en_n    = (state_n == WRITE);
    busy_n     = (state_n != IDLE);
    done_n     = (state_n == DONE);
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed self-checking bench for inst_mem_loader.
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  base_addr;
  logic [5:0]  word_count;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        error;
  logic [5:0]  words_loaded;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int ready_in_write = 0;
  logic [7:0]  wq_addr[$];
  logic [31:0] wq_data[$];

  inst_mem_loader #(.MEM_BYTES(120), .ADDR_W(8), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .word_count(word_count), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Free-running edge counter for latency measurement
  always @(posedge clk) cyc <= cyc + 1;

  // Capture every memory write, and note in_ready overlapping a write cycle
  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      wq_addr.push_back(wr_addr);
      wq_data.push_back(wr_data);
      if (in_ready) ready_in_write++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; start is sampled at the following posedge
  task automatic pulse_start(input logic [7:0] b, input logic [5:0] c);
    base_addr  = b;
    word_count = c;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  // Offer one byte after an idle gap; returns at the negedge after transfer
  task automatic send_byte(input logic [7:0] b, input int gap);
    int k;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    k = 0;
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) check("ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap, inout logic [7:0] sum);
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      b = w[8*i +: 8];
      send_byte(b, (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
      sum = 8'(sum + b);
    end
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!done && k < 60) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
  endtask

  // Full load of one or two words; checksum is the two's complement of the
  // byte sum unless a forced value is given
  task automatic run_load(input string tag, input logic [7:0] base, input logic [5:0] cnt,
                          input logic [31:0] w0, input logic [31:0] w1, input int maxgap,
                          input bit force_ck, input logic [7:0] ck_val,
                          input logic exp_err, output int edges);
    logic [7:0] sum;
    logic [7:0] ck;
    int t0;
    wq_addr.delete();
    wq_data.delete();
    pulse_start(base, cnt);
    t0  = cyc;
    sum = 8'h00;
    send_word(w0, maxgap, sum);
    if (cnt > 6'd1) send_word(w1, maxgap, sum);
    ck = force_ck ? ck_val : 8'(8'h00 - sum);
    send_byte(ck, (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
    wait_done();
    edges = cyc - t0;
    check({tag, "_error"}, {31'd0, error}, {31'd0, exp_err});
    check({tag, "_words"}, {26'd0, words_loaded}, {26'd0, cnt});
    check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd1);
    check({tag, "_nwrites"}, wq_addr.size(), {26'd0, cnt});
    check({tag, "_addr0"}, {24'd0, wq_addr[0]}, {24'd0, base});
    check({tag, "_data0"}, wq_data[0], w0);
    if (cnt > 6'd1) begin
      check({tag, "_addr1"}, {24'd0, wq_addr[1]}, {24'd0, 8'(base + 8'd4)});
      check({tag, "_data1"}, wq_data[1], w1);
    end
    @(negedge clk);
    check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_idle_done"}, {31'd0, done}, 32'd0);
    check({tag, "_hold_data"}, wr_data, (cnt > 6'd1) ? w1 : w0);
  endtask

  // Rejected request: done one cycle after the start edge, no writes
  task automatic bad_start(input string tag, input logic [7:0] base, input logic [5:0] cnt);
    wq_addr.delete();
    pulse_start(base, cnt);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_error"}, {31'd0, error}, 32'd1);
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    check({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check({tag, "_done_off"}, {31'd0, done}, 32'd0);
    check({tag, "_busy_off"}, {31'd0, busy}, 32'd0);
    check({tag, "_ready2"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_nwrites"}, wq_addr.size(), 32'd0);
  endtask

  initial begin
    int edges;
    logic [7:0] s6;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
    in_valid = 1'b0; in_data = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, in_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wr_en", {31'd0, wr_en}, 32'd0);
    check("rst_words", {26'd0, words_loaded}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single word, in_valid held high; 6 edges from start edge to done
    run_load("t1", 8'h00, 6'd1, 32'h00A00093, 32'h0, 0, 1'b0, 8'h00, 1'b0, edges);
    check("t1_latency", edges, 32'd6);

    // 2: two words with random valid gaps; in_ready must be low in WRITE
    ready_in_write = 0;
    run_load("t2", 8'h04, 6'd2, 32'h01400113, 32'h01E00193, 3, 1'b0, 8'h00, 1'b0, edges);
    check("t2_ready_in_write", ready_in_write, 32'd0);

    // 3: bad checksum; word still written, error sticky until next start
    run_load("t3", 8'h00, 6'd1, 32'h00A00093, 32'h0, 0, 1'b1, 8'h00, 1'b1, edges);
    repeat (3) @(negedge clk);
    check("t3_error_sticky", {31'd0, error}, 32'd1);

    // 6: start during RECV ignored; addresses follow the original base
    wq_addr.delete();
    wq_data.delete();
    pulse_start(8'h00, 6'd2);
    check("t6_error_cleared", {31'd0, error}, 32'd0);
    send_byte(8'h13, 0);
    send_byte(8'h01, 0);
    base_addr = 8'h40; word_count = 6'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h40, 0);
    send_byte(8'h01, 0);
    s6 = 8'h55;
    send_word(32'h01E00193, 0, s6);
    send_byte(8'(8'h00 - s6), 0);
    wait_done();
    check("t6_error", {31'd0, error}, 32'd0);
    check("t6_words", {26'd0, words_loaded}, 32'd2);
    check("t6_nwrites", wq_addr.size(), 32'd2);
    check("t6_addr0", {24'd0, wq_addr[0]}, 32'h00);
    check("t6_addr1", {24'd0, wq_addr[1]}, 32'h04);
    check("t6_data0", wq_data[0], 32'h01400113);
    @(negedge clk);

    // 4: misaligned base and overflowing range both rejected
    bad_start("t4a", 8'h02, 6'd1);
    bad_start("t4b", 8'd116, 6'd2);
    bad_start("t4c", 8'h00, 6'd0);

    // 5: reset after two bytes of a word, then a clean load
    wq_addr.delete();
    wq_data.delete();
    pulse_start(8'h00, 6'd1);
    send_byte(8'h93, 0);
    send_byte(8'h00, 0);
    rst_n = 1'b0;
    #1;
    check("t5_ready", {31'd0, in_ready}, 32'd0);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_done", {31'd0, done}, 32'd0);
    check("t5_error", {31'd0, error}, 32'd0);
    check("t5_wr_en", {31'd0, wr_en}, 32'd0);
    check("t5_wr_addr", {24'd0, wr_addr}, 32'd0);
    check("t5_wr_data", wr_data, 32'd0);
    check("t5_words", {26'd0, words_loaded}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_nwrites", wq_addr.size(), 32'd0);
    run_load("t5r", 8'h00, 6'd1, 32'h00A00093, 32'h0, 0, 1'b0, 8'h00, 1'b0, edges);
    check("t5r_latency", edges, 32'd6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
